writeback_regfile: RTL

Writeback-stage consumer of the MEM/WB pipeline register: selects the final result from the ALU result, load data and PC+4, and commits it to a 32-entry x 32-bit integer register file. The block also serves the decode stage's two combinational read ports and keeps a retired-instruction counter. It sits at the tail of the five-stage pipeline and closes the loop back to decode.

---
 rtl/writeback_regfile_if.sv | 32 +++
 rtl/writeback_regfile.sv | 72 +++++++
 2 files changed

// File: rtl/writeback_regfile_if.sv
// Writeback bus between the MEM/WB register, the decode read ports and the register file.
// The master modport is the pipeline side; the slave modport is writeback_regfile.
interface writeback_regfile_if #(
  parameter int DATA_W = 32
);
  logic              valid_w;
  logic              reg_write_w;
  logic [1:0]        result_src_w;
  logic [4:0]        rd_w;
  logic [DATA_W-1:0] alu_result_w;
  logic [DATA_W-1:0] read_data_w;
  logic [DATA_W-1:0] pc_plus_4_w;
  logic [4:0]        rs1_d;
  logic [4:0]        rs2_d;
  logic [DATA_W-1:0] rd1_d;
  logic [DATA_W-1:0] rd2_d;
  logic [DATA_W-1:0] result_w;

  modport master (
    output valid_w, reg_write_w, result_src_w, rd_w,
    output alu_result_w, read_data_w, pc_plus_4_w,
    output rs1_d, rs2_d,
    input  rd1_d, rd2_d, result_w
  );

  modport slave (
    input  valid_w, reg_write_w, result_src_w, rd_w,
    input  alu_result_w, read_data_w, pc_plus_4_w,
    input  rs1_d, rs2_d,
    output rd1_d, rd2_d, result_w
  );
endinterface

// File: rtl/writeback_regfile.sv
// Writeback stage: result select, 32x32 integer register file with two async read ports,
// retired-instruction counter. Define WB_BYPASS_EN for write-first (bypassed) read ports.
module writeback_regfile #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  writeback_regfile_if.slave  wb,
  output logic [CNT_W-1:0]    instret
);

  logic [DATA_W-1:0] regs [32];
  logic [DATA_W-1:0] result;
  logic              commit;

  always_comb begin
    result = wb.alu_result_w;
    case (wb.result_src_w)
      2'b01:   result = wb.read_data_w;
      2'b10:   result = wb.pc_plus_4_w;
      default: result = wb.alu_result_w;
    endcase
  end

  assign wb.result_w = result;
  assign commit = rst_n & wb.valid_w & wb.reg_write_w & (wb.rd_w != 5'd0);

  // Entry 0 is only ever cleared; the read muxes below force x0 to zero regardless.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[wb.rd_w] <= result;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instret <= '0;
    end else if (wb.valid_w) begin
      instret <= instret + CNT_W'(1);
    end
  end

  always_comb begin
    wb.rd1_d = regs[wb.rs1_d];
`ifdef WB_BYPASS_EN
    if (commit && (wb.rs1_d == wb.rd_w)) begin
      wb.rd1_d = result;
    end
`endif
    if (!rst_n || (wb.rs1_d == 5'd0)) begin
      wb.rd1_d = '0;
    end
  end

  always_comb begin
    wb.rd2_d = regs[wb.rs2_d];
`ifdef WB_BYPASS_EN
    if (commit && (wb.rs2_d == wb.rd_w)) begin
      wb.rd2_d = result;
    end
`endif
    if (!rst_n || (wb.rs2_d == 5'd0)) begin
      wb.rd2_d = '0;
    end
  end

endmodule
